uart_imem_loader: RTL
=====================

Name: uart_imem_loader

Overview:
Serial bootloader that writes program images into the processor's instruction memory. It receives 8N1 UART bytes on UART_RXD, assembles them into 32-bit instruction words, and issues write strobes with sequential addresses to the instruction-memory write port. It also reports load progress and errors so the top level can hold the processor in reset until a load completes.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz.
BAUD, 115200, UART bit rate; DIV = CLK_FREQ/BAUD clocks per bit (integer division, DIV >= 4 required).
ADDR_W, 8, instruction-memory address width (matches the 8-bit PC).

Ports:
clk  in  1  system clock (CLOCK_50 at top level).
_rst  in  1  asynchronous, active-low reset.
rxd  in  1  UART receive line, idle high, asynchronous to clk.
wr_en  out  1  one-cycle write strobe to instruction memory.
wr_addr  out  ADDR_W  word address for the current write.
wr_data  out  32  instruction word; first received byte = bits [31:24].
busy  out  1  high from accepted sync byte until DONE or error.
done  out  1  sticky; set on a successful load, cleared by the next sync byte.
csum_err  out  1  sticky; set on checksum mismatch, cleared by the next sync byte.
frame_err  out  1  sticky; set on bad stop bit, cleared by the next sync byte.
word_count  out  ADDR_W+1  number of words written in the current/last load.

Behaviour:
- Reset (async, _rst=0): all outputs 0; both FSMs idle; the rxd synchroniser flops are preset to 1.
- rxd passes through a 2-flop synchroniser; all logic uses the synchronised copy.
- Byte receiver FSM: R_IDLE, R_START, R_DATA, R_STOP.
  - R_IDLE: a synchronised 1->0 transition moves to R_START and loads the bit counter with DIV/2.
  - R_START: when the counter expires, sample the line. Low: go to R_DATA with counter = DIV. High: treat as a glitch and return to R_IDLE with no error.
  - R_DATA: sample every DIV clocks, 8 bits, LSB first, shifted into a byte register.
  - R_STOP: sample after DIV clocks. High: pulse byte_valid for 1 cycle. Low: set frame_err; no byte_valid pulse. Either way, return to R_IDLE.
- Loader FSM: L_SYNC, L_COUNT, L_DATA, L_CSUM, L_DONE. It acts only on byte_valid.
  - L_SYNC: byte 0xA5 clears done, csum_err, frame_err and word_count, sets busy, and moves to L_COUNT. Any other byte is ignored.
  - L_COUNT: the byte is N, the word count; N=0 means 256 words. Clear the address, byte index and checksum; go to L_DATA.
  - L_DATA: shift the byte into a 32-bit assembly register MSB-first and XOR it into the checksum. On the 4th byte, the next cycle drives wr_en=1 with wr_data = assembled word and wr_addr = current address. In that same cycle the address and word_count increment. After word N, go to L_CSUM.
  - L_CSUM: byte equal to the checksum sets done. A mismatch sets csum_err. Either way, go to L_DONE.
  - L_DONE: clear busy and return to L_SYNC in the following cycle.
- Any frame_err while busy aborts the load: return to L_SYNC and clear busy. Words already written stay written.
- Address wrap: the address is ADDR_W bits and wraps to 0 after 2^ADDR_W-1. With N=0 (256 words) and ADDR_W=8, the 256th word lands at 0xFF.
- wr_en is never asserted outside L_DATA. wr_addr and wr_data hold their last values while wr_en=0.
- Latency: the stop-bit sample occurs ~9.5*DIV clocks after the start edge. byte_valid follows it by 1 cycle, and wr_en follows byte_valid by 1 cycle.
- A 0xA5 byte inside L_DATA is treated as data, not as a resync.
- Reset mid-load returns everything to the reset values immediately.

Test Plan:
- The bench uses CLK_FREQ=16, BAUD=1 (DIV=16).
- Basic load: send A5 01 20 08 00 05 2D -> one wr_en pulse with wr_addr=0x00 and wr_data=0x20080005; then done=1, csum_err=0, word_count=1, busy=0.
- Multi-word and address increment: A5 03, then 3 words 0x00000001/0x00000002/0x00000003, then checksum 0x00 -> wr_addr 0,1,2 in order, done=1, word_count=3.
- Checksum error: same as basic load but with final byte 0x2C -> the word is still written, csum_err=1, done=0; a following good load clears csum_err.
- Framing error: drive stop bit low on the 3rd data byte -> frame_err=1, busy=0, no wr_en for that word; the next A5 clears frame_err.
- Glitch and noise: an 8-clock low pulse on rxd, then bytes 0x00 0x7F before A5 -> no byte decoded from the glitch; the leading bytes are ignored; the load proceeds normally.
- Reset mid-load: assert _rst low after 2 data bytes -> all outputs 0 immediately; after release, a fresh load starts at wr_addr=0.

Source files
------------

// File: rtl/uart_imem_loader_if.sv
// Instruction-memory write port shared between the UART loader and the memory.
interface uart_imem_loader_if #(
  parameter int unsigned ADDR_W = 8
) ();
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;

  modport master (output wr_en, output wr_addr, output wr_data);
  modport slave  (input  wr_en, input  wr_addr, input  wr_data);
endinterface

// File: rtl/uart_imem_loader.sv
// UART 8N1 bootloader: receives a framed program image and writes it word by
// word into instruction memory, reporting progress and errors.
// Frame: A5, N (0 = 256 words), N x 4 bytes MSB-first, XOR checksum of data.
module uart_imem_loader #(
  parameter int unsigned CLK_FREQ = 50000000,
  parameter int unsigned BAUD     = 115200,
  parameter int unsigned ADDR_W   = 8
) (
  input  logic                clk,
  input  logic                _rst,
  input  logic                rxd,
  uart_imem_loader_if.master  imem,
  output logic                busy,
  output logic                done,
  output logic                csum_err,
  output logic                frame_err,
  output logic [ADDR_W:0]     word_count
);

  localparam int unsigned DIV   = CLK_FREQ / BAUD;
  localparam int unsigned CNT_W = $clog2(DIV + 1);
  localparam int unsigned CW    = ADDR_W + 1;

  localparam logic [1:0] R_IDLE  = 2'd0;
  localparam logic [1:0] R_START = 2'd1;
  localparam logic [1:0] R_DATA  = 2'd2;
  localparam logic [1:0] R_STOP  = 2'd3;

  localparam logic [2:0] L_SYNC  = 3'd0;
  localparam logic [2:0] L_COUNT = 3'd1;
  localparam logic [2:0] L_DATA  = 3'd2;
  localparam logic [2:0] L_CSUM  = 3'd3;
  localparam logic [2:0] L_DONE  = 3'd4;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  // ---------------- rxd synchroniser ----------------
  logic rx_meta, rx_sync, rx_prev;

  // Two-flop synchroniser plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // ---------------- byte receiver ----------------
  logic [1:0]       r_state_q, r_state_d;
  logic [CNT_W-1:0] r_cnt_q, r_cnt_d;
  logic [2:0]       r_bit_q, r_bit_d;
  logic [7:0]       r_shift_q, r_shift_d;
  logic             byte_valid_q, byte_valid_d;
  logic             frame_evt_q, frame_evt_d;
  logic             r_expire;

  assign r_expire = (r_cnt_q == CNT_W'(1));

  // Receiver next-state: mid-bit sampling driven by a down-counter.
  always_comb begin
    r_state_d    = r_state_q;
    r_cnt_d      = r_cnt_q;
    r_bit_d      = r_bit_q;
    r_shift_d    = r_shift_q;
    byte_valid_d = 1'b0;
    frame_evt_d  = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        if (rx_prev && !rx_sync) begin
          r_state_d = R_START;
          r_cnt_d   = CNT_W'(DIV / 2);
        end
      end
      R_START: begin
        if (r_expire) begin
          if (!rx_sync) begin
            r_state_d = R_DATA;
            r_cnt_d   = CNT_W'(DIV);
            r_bit_d   = 3'd0;
          end else begin
            r_state_d = R_IDLE;
          end
        end else begin
          r_cnt_d = r_cnt_q - CNT_W'(1);
        end
      end
      R_DATA: begin
        if (r_expire) begin
          r_shift_d = {rx_sync, r_shift_q[7:1]};
          r_cnt_d   = CNT_W'(DIV);
          if (r_bit_q == 3'd7) begin
            r_state_d = R_STOP;
          end else begin
            r_bit_d = r_bit_q + 3'd1;
          end
        end else begin
          r_cnt_d = r_cnt_q - CNT_W'(1);
        end
      end
      R_STOP: begin
        if (r_expire) begin
          r_state_d = R_IDLE;
          if (rx_sync) begin
            byte_valid_d = 1'b1;
          end else begin
            frame_evt_d = 1'b1;
          end
        end else begin
          r_cnt_d = r_cnt_q - CNT_W'(1);
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Receiver state register.
  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      r_state_q    <= R_IDLE;
      r_cnt_q      <= '0;
      r_bit_q      <= '0;
      r_shift_q    <= '0;
      byte_valid_q <= 1'b0;
      frame_evt_q  <= 1'b0;
    end else begin
      r_state_q    <= r_state_d;
      r_cnt_q      <= r_cnt_d;
      r_bit_q      <= r_bit_d;
      r_shift_q    <= r_shift_d;
      byte_valid_q <= byte_valid_d;
      frame_evt_q  <= frame_evt_d;
    end
  end

  // ---------------- loader ----------------
  logic [2:0]        l_state_q, l_state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              csum_err_q, csum_err_d;
  logic              frame_err_q, frame_err_d;
  logic [CW-1:0]     word_count_q, word_count_d;
  logic [CW-1:0]     n_words_q, n_words_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [23:0]       asm_q, asm_d;
  logic [1:0]        bidx_q, bidx_d;
  logic [7:0]        csum_q, csum_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]       wr_data_q, wr_data_d;
  logic [7:0]        rx_byte;

  assign rx_byte = r_shift_q;

  // Loader next-state: frame errors abort a load; otherwise act on each byte.
  always_comb begin
    l_state_d    = l_state_q;
    busy_d       = busy_q;
    done_d       = done_q;
    csum_err_d   = csum_err_q;
    frame_err_d  = frame_err_q;
    word_count_d = word_count_q;
    n_words_d    = n_words_q;
    addr_d       = addr_q;
    asm_d        = asm_q;
    bidx_d       = bidx_q;
    csum_d       = csum_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    if (frame_evt_q) begin
      frame_err_d = 1'b1;
      if (busy_q) begin
        l_state_d = L_SYNC;
        busy_d    = 1'b0;
      end
    end else if (l_state_q == L_DONE) begin
      busy_d    = 1'b0;
      l_state_d = L_SYNC;
    end else if (byte_valid_q) begin
      case (l_state_q)
        L_SYNC: begin
          if (rx_byte == SYNC_BYTE) begin
            done_d       = 1'b0;
            csum_err_d   = 1'b0;
            frame_err_d  = 1'b0;
            word_count_d = '0;
            busy_d       = 1'b1;
            l_state_d    = L_COUNT;
          end
        end
        L_COUNT: begin
          n_words_d = (rx_byte == 8'd0) ? CW'(256) : CW'(rx_byte);
          addr_d    = '0;
          bidx_d    = '0;
          csum_d    = '0;
          l_state_d = L_DATA;
        end
        L_DATA: begin
          asm_d  = {asm_q[15:0], rx_byte};
          csum_d = csum_q ^ rx_byte;
          bidx_d = bidx_q + 2'd1;
          if (bidx_q == 2'd3) begin
            wr_en_d      = 1'b1;
            wr_addr_d    = addr_q;
            wr_data_d    = {asm_q, rx_byte};
            addr_d       = addr_q + ADDR_W'(1);
            word_count_d = word_count_q + CW'(1);
            if (word_count_q + CW'(1) == n_words_q) begin
              l_state_d = L_CSUM;
            end
          end
        end
        L_CSUM: begin
          if (rx_byte == csum_q) begin
            done_d = 1'b1;
          end else begin
            csum_err_d = 1'b1;
          end
          l_state_d = L_DONE;
        end
        default: l_state_d = L_SYNC;
      endcase
    end
  end

  // Loader state and output registers.
  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      l_state_q    <= L_SYNC;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      csum_err_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      word_count_q <= '0;
      n_words_q    <= '0;
      addr_q       <= '0;
      asm_q        <= '0;
      bidx_q       <= '0;
      csum_q       <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      l_state_q    <= l_state_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      csum_err_q   <= csum_err_d;
      frame_err_q  <= frame_err_d;
      word_count_q <= word_count_d;
      n_words_q    <= n_words_d;
      addr_q       <= addr_d;
      asm_q        <= asm_d;
      bidx_q       <= bidx_d;
      csum_q       <= csum_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
    end
  end

  assign imem.wr_en   = wr_en_q;
  assign imem.wr_addr = wr_addr_q;
  assign imem.wr_data = wr_data_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign csum_err     = csum_err_q;
  assign frame_err    = frame_err_q;
  assign word_count   = word_count_q;

endmodule
